numberle_display_ctrl: RTL and testbench
========================================

# numberle_display_ctrl

Parametrised guess-entry and display controller for the Numberle board: captures keypad digits into an N-digit guess, moves an edit cursor with buttons, scores submitted guesses against a secret, and multiplexes guess/feedback codes onto the seven-segment anodes. Sits between the keypad decoder (DispVal) and the hex-to-segment decoder (hex_out), with game progress on the LEDs.

## Interface
- NUM_DIGITS, 4: digits per guess/display, 2..8
- MAX_TRIES, 6: guesses allowed before LOSE, 1..15
- SCAN_DIV, 100000: clock cycles per display digit slot, ≥2
- DEBOUNCE_CYCLES, 500000: stable cycles required per button level (only with debounce compiled in)

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- btnR  in  1  raw button: cursor right
- btnL  in  1  raw button: cursor left
- btnU  in  1  raw button: submit / continue / restart
- DispVal  in  4  keypad value; 4'hF = no key held
- secret  in  4*NUM_DIGITS  target digits, digit i at [4i+3:4i]; sampled only on submit
- anode  out  NUM_DIGITS  active-low digit enable, at most one low
- hex_out  out  4  code for the enabled digit
- dp  out  1  active-low decimal point for the enabled digit
- led  out  16  progress LEDs

## Operation
- Buttons: 2-flop synchroniser, then rising-edge detect; one pulse per press.
- Key press: DispVal transition from 4'hF to 0..9 (registered previous value). Values A..E ignored. Held key writes once.
- Same-cycle events: priority btnU > btnR > btnL > key; lower-priority events in that cycle dropped.
- State ENTRY (reset state):
  - key writes guess digit [cursor]; cursor unchanged.
  - btnR: cursor+1, wraps NUM_DIGITS-1→0. btnL: cursor-1, wraps 0→NUM_DIGITS-1.
  - btnU: ignored if any guess digit is 4'hF; else score, tries+1, go to FEEDBACK.
- Scoring (one registered cycle): per digit i: 4'hA if guess[i]==secret[i]; else 4'hB if guess[i] equals secret[j] for any j≠i; else 4'hC. No duplicate accounting.
- State FEEDBACK: keys/btnR/btnL ignored. btnU: all codes A → WIN; else tries==MAX_TRIES → LOSE; else guess all 4'hF, cursor 0, → ENTRY.
- WIN/LOSE: btnU restarts: guess all F, cursor 0, tries 0, feedback cleared, led 0, → ENTRY.
- Display source by state: ENTRY guess digit; FEEDBACK/WIN feedback code; LOSE secret digit (captured at last submit).
- dp low only in ENTRY on the cursor digit.
- led[MAX_TRIES-1:0]: thermometer of tries used; led[15]=1 in WIN only; other bits 0.

## Timing
- Reset values: anode all 1, hex_out 4'hF, dp 1, led 0; state ENTRY, guess all 4'hF, cursor 0, tries 0, scan index 0, prescaler 0.
- Reset mid-operation: all of the above next clock edge, regardless of state.
- Button latency (no debounce): raw high sampled at edge 0 → state/cursor update at edge 3.
- Key latency: DispVal change sampled at edge 0 → guess updated at edge 1.
- Submit→FEEDBACK: feedback codes valid the same edge state becomes FEEDBACK.
- Scan: prescaler counts 0..SCAN_DIV-1; at wrap scan index increments, wraps NUM_DIGITS-1→0 (non-power-of-2 allowed). anode/hex_out/dp registered, update one cycle after index change; never two anodes low.
- Outputs of first slot appear SCAN_DIV+1 cycles after reset release; anodes stay 1 until then.
- tries saturates at MAX_TRIES; never wraps.

## Configuration
- NUMBERLE_DEBOUNCE_EN defined: each synchronised button passes a counter filter; level accepted only after DEBOUNCE_CYCLES consecutive equal samples; edge detect on the filtered level; adds DEBOUNCE_CYCLES to button latency.
- Undefined: no filter; DEBOUNCE_CYCLES unused; latency as in Timing.

## Test plan
- Reset, NUM_DIGITS=4, SCAN_DIV=4: anode cycles 1110,1101,1011,0111, hex_out 4'hF, dp low only in slot 0 -> cursor 0.
- Keys 1,btnR,2,btnR,3,btnR,4; btnL four times -> guess 4321 (digit3..0), cursor 3 after rightmoves then wraps back to 3 after four lefts.
- Guess 1234 (digit0=1..digit3=4), secret 1342, btnU -> hex_out A,B,B,B per digit 0..3, led[0]=1, dp all high; btnU -> ENTRY, guess all F.
- btnU with digit 2 still F -> state stays ENTRY, led unchanged; btnU and btnR same cycle -> only submit acted on.
- Guess == secret, btnU, btnU -> WIN, all digits 4'hA, led[15]=1; btnU -> led 0, ENTRY.
- MAX_TRIES=2, two wrong guesses, btnU -> LOSE, secret digits displayed; reset asserted mid-FEEDBACK -> all reset values next edge.

Source files
------------

// File: rtl/numberle_display_ctrl.sv
// Numberle guess-entry, scoring and seven-segment scan controller.
// Optional button debounce filter is compiled in with NUMBERLE_DEBOUNCE_EN.
module numberle_display_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int MAX_TRIES       = 6,
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    btnR,
  input  logic                    btnL,
  input  logic                    btnU,
  input  logic [3:0]              DispVal,
  input  logic [4*NUM_DIGITS-1:0] secret,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [3:0]              hex_out,
  output logic                    dp,
  output logic [15:0]             led
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] MAX_T      = TW'(MAX_TRIES);
  localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);
`ifdef NUMBERLE_DEBOUNCE_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_ENTRY, S_FEEDBACK, S_WIN, S_LOSE} state_e;
  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  state_e          state_q, state_d;
  digits_t         guess_q, guess_d, fb_q, fb_d, sec_q, sec_d, score, sec_in;
  logic [IW-1:0]   cursor_q, cursor_d, scan_idx_q;
  logic [TW-1:0]   tries_q, tries_d;
  logic [PW-1:0]   presc_q;
  logic            scan_on_q;
  logic [2:0]      sync1_q, sync2_q, lvl_prev_q, pulse_q, btn_lvl;
  logic [3:0]      key_q, key_prev_q;
  logic            key_press, guess_full, all_a;
  logic [NUM_DIGITS-1:0] anode_d, anode_q;
  logic [3:0]      hex_d, hex_q;
  logic            dp_d, dp_q;

  assign sec_in = secret;

  // Button order in the vectors: [2]=U, [1]=R, [0]=L.
  // NOTE: every clocked register uses <= so all flops sample pre-edge values; blocking here would chain the synchroniser into one stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
      pulse_q    <= '0;
      key_q      <= 4'hF;
      key_prev_q <= 4'hF;
    end else begin
      sync1_q    <= {btnU, btnR, btnL};
      sync2_q    <= sync1_q;
      lvl_prev_q <= btn_lvl;
      pulse_q    <= btn_lvl & ~lvl_prev_q;
      key_q      <= DispVal;
      key_prev_q <= key_q;
    end
  end

  if (FILTER_ON && DEBOUNCE_CYCLES > 0) begin : g_debounce
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    logic [DW-1:0] cnt_q [3];
    logic [2:0]    filt_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        filt_q <= '0;
        for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
      end else begin
        for (int b = 0; b < 3; b++) begin
          if (sync2_q[b] == filt_q[b]) begin
            cnt_q[b] <= '0;
          end else if (cnt_q[b] == DB_LAST) begin
            filt_q[b] <= sync2_q[b];
            cnt_q[b]  <= '0;
          end else begin
            cnt_q[b] <= cnt_q[b] + DW'(1);
          end
        end
      end
    end
    assign btn_lvl = filt_q;
  end else begin : g_bypass
    assign btn_lvl = sync2_q;
  end

  // A press is the first sample of 0..9 after "no key"; holding writes once.
  assign key_press = (key_prev_q == 4'hF) && (key_q <= 4'd9);

  always_comb begin
    score      = '1;
    guess_full = 1'b1;
    all_a      = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      score[i] = 4'hC;
      for (int j = 0; j < NUM_DIGITS; j++)
        if (j != i && guess_q[i] == sec_in[j]) score[i] = 4'hB;
      if (guess_q[i] == sec_in[i]) score[i] = 4'hA;
      if (guess_q[i] == 4'hF) guess_full = 1'b0;
      if (fb_q[i] != 4'hA) all_a = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_ENTRY;
      guess_q  <= '1;
      cursor_q <= '0;
      tries_q  <= '0;
      fb_q     <= '1;
      sec_q    <= '1;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      cursor_q <= cursor_d;
      tries_q  <= tries_d;
      fb_q     <= fb_d;
      sec_q    <= sec_d;
    end
  end

  // Priority U > R > L > key; a lower event in the same cycle is dropped.
  // NOTE: every combinational output gets a hold value first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    cursor_d = cursor_q;
    tries_d  = tries_q;
    fb_d     = fb_q;
    sec_d    = sec_q;
    unique case (state_q)
      S_ENTRY: begin
        if (pulse_q[2]) begin
          if (guess_full) begin
            fb_d    = score;
            sec_d   = sec_in;
            tries_d = (tries_q == MAX_T) ? tries_q : tries_q + TW'(1);
            state_d = S_FEEDBACK;
          end
        end else if (pulse_q[1]) begin
          cursor_d = (cursor_q == LAST_IDX) ? '0 : cursor_q + IW'(1);
        end else if (pulse_q[0]) begin
          cursor_d = (cursor_q == '0) ? LAST_IDX : cursor_q - IW'(1);
        end else if (key_press) begin
          guess_d[cursor_q] = key_q;
        end
      end
      S_FEEDBACK: begin
        if (pulse_q[2]) begin
          if (all_a) begin
            state_d = S_WIN;
          end else if (tries_q == MAX_T) begin
            state_d = S_LOSE;
          end else begin
            guess_d  = '1;
            cursor_d = '0;
            state_d  = S_ENTRY;
          end
        end
      end
      default: begin
        if (pulse_q[2]) begin
          guess_d  = '1;
          cursor_d = '0;
          tries_d  = '0;
          fb_d     = '1;
          state_d  = S_ENTRY;
        end
      end
    endcase
  end

  // The first prescaler wrap only enables the scan, so slot 0 shows first.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q    <= '0;
      scan_idx_q <= '0;
      scan_on_q  <= 1'b0;
      anode_q    <= '1;
      hex_q      <= 4'hF;
      dp_q       <= 1'b1;
    end else begin
      presc_q <= (presc_q == LAST_PRESC) ? '0 : presc_q + PW'(1);
      if (presc_q == LAST_PRESC) begin
        if (!scan_on_q) scan_on_q <= 1'b1;
        else scan_idx_q <= (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + IW'(1);
      end
      anode_q <= anode_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      anode_d[i] = !(scan_on_q && scan_idx_q == IW'(i));
    unique case (state_q)
      S_ENTRY: hex_d = guess_q[scan_idx_q];
      S_LOSE:  hex_d = sec_q[scan_idx_q];
      default: hex_d = fb_q[scan_idx_q];
    endcase
    if (!scan_on_q) hex_d = 4'hF;
    dp_d = !(scan_on_q && state_q == S_ENTRY && scan_idx_q == cursor_q);
    led = '0;
    for (int i = 0; i < MAX_TRIES; i++) led[i] = (TW'(i) < tries_q);
    led[15] = (state_q == S_WIN);
  end

  assign anode   = anode_q;
  assign hex_out = hex_q;
  assign dp      = dp_q;
endmodule

// File: tb/tb_numberle_display_ctrl.sv
// Bench for numberle_display_ctrl: directed vector table, latency and reset
// sequences, then random play checked against a game-level model.
module tb_numberle_display_ctrl;
  localparam int ND = 4;
  localparam int MT = 2;
  localparam int SD = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              btnR = 1'b0, btnL = 1'b0, btnU = 1'b0;
  logic [3:0]        DispVal = 4'hF;
  logic [4*ND-1:0]   secret = '0;
  logic [ND-1:0]     anode;
  logic [3:0]        hex_out;
  logic              dp;
  logic [15:0]       led;

  numberle_display_ctrl #(
    .NUM_DIGITS(ND), .MAX_TRIES(MT), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset), .btnR(btnR), .btnL(btnL), .btnU(btnU),
    .DispVal(DispVal), .secret(secret), .anode(anode), .hex_out(hex_out),
    .dp(dp), .led(led)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  typedef enum int {A_KEY, A_R, A_L, A_U, A_UR} act_e;
  typedef enum int {M_ENTRY, M_FB, M_WIN, M_LOSE} mstate_e;

  typedef struct {
    act_e            act;
    logic [3:0]      val;
    logic [4*ND-1:0] hex;
    int              dps;
    logic [15:0]     led;
  } vec_t;

  vec_t tbl[$];

  mstate_e m_state;
  int m_guess[ND], m_fb[ND], m_sec[ND];
  int m_cur, m_tries;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic void add(act_e a, logic [3:0] v, logic [4*ND-1:0] h, int d, logic [15:0] l);
    vec_t e;
    e.act = a; e.val = v; e.hex = h; e.dps = d; e.led = l;
    tbl.push_back(e);
  endfunction

  task automatic do_act(input act_e act, input logic [3:0] v);
    if (act == A_KEY) begin
      DispVal = v;
      tick(2);
      DispVal = 4'hF;
      tick(4);
    end else begin
      btnU = (act == A_U) || (act == A_UR);
      btnR = (act == A_R) || (act == A_UR);
      btnL = (act == A_L);
      tick(2);
      btnU = 1'b0; btnR = 1'b0; btnL = 1'b0;
      tick(6);
    end
  endtask

  // Walk one full scan and compare each slot's code and decimal point.
  task automatic check_disp(input string name, input logic [4*ND-1:0] exp_hex, input int exp_dp);
    logic [ND-1:0] want;
    int waited;
    for (int k = 0; k < ND; k++) begin
      want = '1;
      want[k] = 1'b0;
      waited = 0;
      @(negedge clock);
      while (anode !== want && waited < 64) begin
        @(negedge clock);
        waited++;
      end
      check($sformatf("%s anode slot%0d", name, k), 32'(anode), 32'(want));
      check($sformatf("%s hex slot%0d", name, k), 32'(hex_out), 32'(exp_hex[4*k +: 4]));
      check($sformatf("%s dp slot%0d", name, k), 32'(dp), (k == exp_dp) ? 32'd0 : 32'd1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check({name, " reset anode"}, 32'(anode), 32'hF);
    check({name, " reset hex"}, 32'(hex_out), 32'hF);
    check({name, " reset dp"}, 32'(dp), 32'd1);
    check({name, " reset led"}, 32'(led), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int n = 0; n <= SD + 1; n++) begin
      @(negedge clock);
      if (n <= SD) check($sformatf("%s idle anode c%0d", name, n), 32'(anode), 32'hF);
      else         check({name, " first slot anode"}, 32'(anode), 32'b1110);
    end
    check_disp({name, " entry"}, '1, 0);
    check({name, " entry led"}, 32'(led), 32'd0);
  endtask

  task automatic model_reset();
    m_state = M_ENTRY;
    m_cur = 0;
    m_tries = 0;
    for (int i = 0; i < ND; i++) begin
      m_guess[i] = 15; m_fb[i] = 15; m_sec[i] = 15;
    end
  endtask

  task automatic model_apply(input act_e act, input int v);
    bit full, win, hit;
    full = 1'b1;
    win = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (m_guess[i] == 15) full = 1'b0;
      if (m_fb[i] != 10) win = 1'b0;
    end
    if (act == A_U || act == A_UR) begin
      case (m_state)
        M_ENTRY: if (full) begin
          for (int i = 0; i < ND; i++) begin
            m_sec[i] = int'(secret[4*i +: 4]);
            hit = 1'b0;
            for (int j = 0; j < ND; j++)
              if (j != i && m_guess[i] == int'(secret[4*j +: 4])) hit = 1'b1;
            if (m_guess[i] == m_sec[i]) m_fb[i] = 10;
            else m_fb[i] = hit ? 11 : 12;
          end
          if (m_tries < MT) m_tries++;
          m_state = M_FB;
        end
        M_FB: begin
          if (win) m_state = M_WIN;
          else if (m_tries == MT) m_state = M_LOSE;
          else begin
            for (int i = 0; i < ND; i++) m_guess[i] = 15;
            m_cur = 0;
            m_state = M_ENTRY;
          end
        end
        default: begin
          model_reset();
        end
      endcase
    end else if (m_state == M_ENTRY) begin
      if (act == A_R) m_cur = (m_cur + 1) % ND;
      else if (act == A_L) m_cur = (m_cur + ND - 1) % ND;
      else if (v <= 9) m_guess[m_cur] = v;
    end
  endtask

  function automatic logic [4*ND-1:0] model_hex();
    logic [4*ND-1:0] h;
    h = '0;
    for (int i = 0; i < ND; i++) begin
      case (m_state)
        M_ENTRY: h[4*i +: 4] = 4'(m_guess[i]);
        M_LOSE:  h[4*i +: 4] = 4'(m_sec[i]);
        default: h[4*i +: 4] = 4'(m_fb[i]);
      endcase
    end
    return h;
  endfunction

  function automatic logic [15:0] model_led();
    logic [15:0] l;
    l = 16'((1 << m_tries) - 1);
    if (m_state == M_WIN) l[15] = 1'b1;
    return l;
  endfunction

  initial begin
    // Secret digit0..3 = 1,3,4,2.
    add(A_KEY, 4'd1, 16'hFFF1, 0, 16'h0000);
    add(A_R,   4'd0, 16'hFFF1, 1, 16'h0000);
    add(A_KEY, 4'd2, 16'hFF21, 1, 16'h0000);
    add(A_R,   4'd0, 16'hFF21, 2, 16'h0000);
    add(A_KEY, 4'd3, 16'hF321, 2, 16'h0000);
    add(A_R,   4'd0, 16'hF321, 3, 16'h0000);
    add(A_KEY, 4'd4, 16'h4321, 3, 16'h0000);
    add(A_L,   4'd0, 16'h4321, 2, 16'h0000);
    add(A_L,   4'd0, 16'h4321, 1, 16'h0000);
    add(A_L,   4'd0, 16'h4321, 0, 16'h0000);
    add(A_L,   4'd0, 16'h4321, 3, 16'h0000);
    add(A_U,   4'd0, 16'hBBBA, -1, 16'h0001);
    add(A_U,   4'd0, 16'hFFFF, 0, 16'h0001);
    add(A_KEY, 4'd5, 16'hFFF5, 0, 16'h0001);
    add(A_R,   4'd0, 16'hFFF5, 1, 16'h0001);
    add(A_KEY, 4'd6, 16'hFF65, 1, 16'h0001);
    add(A_R,   4'd0, 16'hFF65, 2, 16'h0001);
    add(A_R,   4'd0, 16'hFF65, 3, 16'h0001);
    add(A_KEY, 4'd7, 16'h7F65, 3, 16'h0001);
    add(A_U,   4'd0, 16'h7F65, 3, 16'h0001);
    add(A_UR,  4'd0, 16'h7F65, 3, 16'h0001);
    add(A_L,   4'd0, 16'h7F65, 2, 16'h0001);
    add(A_KEY, 4'hA, 16'h7F65, 2, 16'h0001);
    add(A_KEY, 4'd8, 16'h7865, 2, 16'h0001);
    add(A_UR,  4'd0, 16'hCCCC, -1, 16'h0003);
    add(A_KEY, 4'd9, 16'hCCCC, -1, 16'h0003);
    add(A_R,   4'd0, 16'hCCCC, -1, 16'h0003);
    add(A_U,   4'd0, 16'h2431, -1, 16'h0003);
    add(A_U,   4'd0, 16'hFFFF, 0, 16'h0000);
    add(A_KEY, 4'd1, 16'hFFF1, 0, 16'h0000);
    add(A_R,   4'd0, 16'hFFF1, 1, 16'h0000);
    add(A_KEY, 4'd3, 16'hFF31, 1, 16'h0000);
    add(A_R,   4'd0, 16'hFF31, 2, 16'h0000);
    add(A_KEY, 4'd4, 16'hF431, 2, 16'h0000);
    add(A_R,   4'd0, 16'hF431, 3, 16'h0000);
    add(A_KEY, 4'd2, 16'h2431, 3, 16'h0000);
    add(A_U,   4'd0, 16'hAAAA, -1, 16'h0001);
    add(A_U,   4'd0, 16'hAAAA, -1, 16'h8001);
    add(A_U,   4'd0, 16'hFFFF, 0, 16'h0000);

    secret = 16'h2431;
    tick(1);
    do_reset("init");

    foreach (tbl[n]) begin
      do_act(tbl[n].act, tbl[n].val);
      check_disp($sformatf("vec%0d", n), tbl[n].hex, tbl[n].dps);
      check($sformatf("vec%0d led", n), 32'(led), 32'(tbl[n].led));
    end

    // Submit latency: raw btnU seen at edge 0, led moves at edge 3.
    for (int i = 0; i < ND; i++) begin
      do_act(A_KEY, 4'd9);
      if (i < ND - 1) do_act(A_R, 4'd0);
    end
    btnU = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      if (k == 3) check("submit latency edge2 led", 32'(led), 32'h0);
      if (k == 4) check("submit latency edge3 led", 32'(led), 32'h1);
    end
    btnU = 1'b0;
    tick(6);
    check_disp("latency fb", 16'hCCCC, -1);

    do_reset("mid feedback");

    model_reset();
    for (int it = 0; it < 120; it++) begin
      int r, v;
      act_e a;
      bit full;
      r = $urandom_range(0, 9);
      v = $urandom_range(0, 15);
      a = (r <= 4) ? A_KEY : (r == 5) ? A_R : (r == 6) ? A_L : (r == 9) ? A_UR : A_U;
      full = 1'b1;
      for (int i = 0; i < ND; i++) if (m_guess[i] == 15) full = 1'b0;
      for (int i = 0; i < ND; i++)
        secret[4*i +: 4] = (full && $urandom_range(0, 1) == 1) ? 4'(m_guess[i]) : 4'($urandom_range(0, 9));
      do_act(a, 4'(v));
      model_apply(a, v);
      check_disp($sformatf("rand%0d", it), model_hex(), (m_state == M_ENTRY) ? m_cur : -1);
      check($sformatf("rand%0d led", it), 32'(led), 32'(model_led()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
